// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that ripples CHUNK bits per clock
// through a chain of full-adder cells, carrying between chunks in a register.
// Operands are accepted on a valid/ready handshake; the result is presented on
// a second valid/ready handshake with carry-out and signed-overflow flags.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    // Counter must be at least one bit wide even when a single chunk covers WIDTH
    localparam int unsigned CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] chunk_sum;
    logic             rc;
    logic             c_msb_in;
    logic             c_out;
    logic [WIDTH-1:0] sum_shift;

    // Ripple of CHUNK full-adder cells over the low bits of the operand registers
    always_comb begin
        chunk_sum = '0;
        rc        = carry_q;
        c_msb_in  = carry_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            // Carry entering the top cell of the chunk feeds the overflow flag
            c_msb_in     = rc;
            chunk_sum[i] = a_q[i] ^ b_q[i] ^ rc;
            rc           = (a_q[i] & b_q[i]) | (rc & (a_q[i] ^ b_q[i]));
        end
        c_out = rc;
    end

    // New chunk enters the result from the MSB side so the last chunk lands on top
    always_comb begin
        sum_shift                      = sum_q >> CHUNK;
        sum_shift[WIDTH-1 -: CHUNK]    = chunk_sum;
    end

    // Control FSM, operand/carry datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        // Subtraction is a + ~b + !cin: invert B and the carry-in here
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= cin ^ sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    sum_q   <= sum_shift;
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= c_out;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CHUNK) begin
                        cout_q      <= c_out;
                        ovf_q       <= c_msb_in ^ c_out;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: main instance with CHUNK=4 plus
// CHUNK=1 and CHUNK=16 instances for the latency extremes.
module tb_chunked_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_ready;

    logic         in_valid, in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    logic         in_valid1, in_ready1, out_valid1, cout1, ovf1;
    logic [W-1:0] sum1;
    logic         in_valid16, in_ready16, out_valid16, cout16, ovf16;
    logic [W-1:0] sum16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    chunked_adder #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
        .cout(cout1), .ovf(ovf1)
    );

    chunked_adder #(.WIDTH(W), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: integer add with sign-rule overflow
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W:0] full;
        exp_t       e;
        if (!s) begin
            full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            e.ovf = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full  = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~c};
            e.ovf = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end
        e.sum  = full[W-1:0];
        e.cout = full[W];
        return e;
    endfunction

    // Present one operation on the main instance; returns just after the accept edge
    task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic s);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL reset_result: sum=%h cout=%b ovf=%b want 0000 0 0", sum, cout, ovf);
        end else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end else n_pass++;
        n_checks++;
        if (in_ready1 !== 1'b1 || in_ready16 !== 1'b1 || out_valid1 !== 1'b0
            || out_valid16 !== 1'b0) begin
            $display("FAIL reset_variants: in_ready1=%b in_ready16=%b want 1 1",
                     in_ready1, in_ready16);
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        vec_t v[9];
        exp_t e;
        int   lat;
        v = '{
            '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
            '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0},
            '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
            '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0},
            '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
            '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_op(v[i].a, v[i].b, v[i].cin, v[i].sub);
            e.sum = v[i].s; e.cout = v[i].co; e.ovf = v[i].ov;
            sb.push_back(e);
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            n_checks++;
            if (lat !== 4) $display("FAIL basic_latency[%0d]: got %0d want 4", i, lat);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL basic_result[%0d]: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                    $display("FAIL basic_result[%0d]: sum=%h cout=%b ovf=%b want %h %b %b",
                             i, sum, cout, ovf, e.sum, e.cout, e.ovf);
                end else n_pass++;
            end
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL basic_release[%0d]: in_ready=%b out_valid=%b want 1 0",
                         i, in_ready, out_valid);
            end else n_pass++;
        end
    endtask

    task automatic test_chunk_variants();
        exp_t e;
        int   lat1, lat16;
        lat1 = 0; lat16 = 0;
        out_ready = 1'b1;
        e = model(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b1; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid16 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid1 && lat1 == 0) lat1 = k;
            if (out_valid16 && lat16 == 0) lat16 = k;
        end
        n_checks++;
        if (lat1 !== 16) $display("FAIL chunk1_latency: got %0d want 16", lat1);
        else n_pass++;
        n_checks++;
        if (lat16 !== 1) $display("FAIL chunk16_latency: got %0d want 1", lat16);
        else n_pass++;
        n_checks++;
        if ({sum1, cout1, ovf1} !== {e.sum, e.cout, e.ovf}) begin
            $display("FAIL chunk1_result: sum=%h cout=%b ovf=%b want %h %b %b",
                     sum1, cout1, ovf1, e.sum, e.cout, e.ovf);
        end else n_pass++;
        n_checks++;
        if ({sum16, cout16, ovf16} !== {e.sum, e.cout, e.ovf}) begin
            $display("FAIL chunk16_result: sum=%h cout=%b ovf=%b want %h %b %b",
                     sum16, cout16, ovf16, e.sum, e.cout, e.ovf);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        drive_op(16'hA5A5, 16'h0F0F, 1'b1, 1'b1);
        sb.push_back(model(16'hA5A5, 16'h0F0F, 1'b1, 1'b1));
        // Operand and valid churn while busy must be ignored
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 4) $display("FAIL bp_latency: got %0d want 4", lat);
        else n_pass++;
        if (sb.size() != 0) e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                         k, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end else n_pass++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end else n_pass++;
        n_checks++;
        if (sum !== e.sum) $display("FAIL bp_sum_held: sum=%h want %h", sum, e.sum);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[3];
        logic [W-1:0] ob[3];
        logic         oc[3];
        logic         os[3];
        exp_t         e;
        int           acc, got, cyc, last;
        logic         fire_in, fire_out;
        for (int i = 0; i < 3; i++) begin
            oa[i] = W'($urandom); ob[i] = W'($urandom);
            oc[i] = 1'($urandom); os[i] = 1'($urandom);
        end
        acc = 0; got = 0; cyc = 0; last = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = oa[0]; b = ob[0]; cin = oc[0]; sub = os[0]; in_valid = 1'b1;
        while (got < 3 && cyc < 200) begin
            @(negedge clk);
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_result[%0d]: scoreboard empty", got);
                end else begin
                    e = sb.pop_front();
                    if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        $display("FAIL b2b_result[%0d]: sum=%h cout=%b ovf=%b want %h %b %b",
                                 got, sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end else n_pass++;
                end
                got++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (fire_in) begin
                sb.push_back(model(oa[acc], ob[acc], oc[acc], os[acc]));
                if (acc > 0) begin
                    // 4 RUN cycles, 1 DONE cycle, 1 IDLE cycle between accept edges
                    n_checks++;
                    if (cyc - last !== 6) begin
                        $display("FAIL b2b_spacing[%0d]: got %0d want 6", acc, cyc - last);
                    end else n_pass++;
                end
                last = cyc;
                acc++;
                if (acc < 3) begin
                    a = oa[acc]; b = ob[acc]; cin = oc[acc]; sub = os[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (got !== 3) $display("FAIL b2b_count: got %0d results want 3", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        drive_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL midrst_result: sum=%h cout=%b ovf=%b want 0000 0 0", sum, cout, ovf);
        end else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midrst_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end else n_pass++;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        e.sum = 16'h0002; e.cout = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 4) $display("FAIL midrst_latency: got %0d want 4", lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL midrst_after: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                $display("FAIL midrst_after: sum=%h cout=%b ovf=%b want %h %b %b",
                         sum, cout, ovf, e.sum, e.cout, e.ovf);
            end else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_valid1 = 1'b0; in_valid16 = 1'b0;
        test_reset();
        test_basic();
        test_chunk_variants();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
